// File: rtl/reg32_serial_tx.sv
// reg32_serial_tx: bit-serial transmitter for parallel capture words.
// A word is taken on an En/Ready handshake and sent as a start bit (0),
// WIDTH data bits MSB first, then a stop bit (1). Every bit is held for
// CLKS_PER_BIT clocks. All outputs come from state and registered counters,
// so En and Data_In have no combinational path to any output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, Ready=1, waiting for En
// S_START | line low for one bit time
// S_DATA  | line follows shift register MSB, Frame=1, WIDTH bit times
// S_STOP  | line high for one bit time, Done on the final cycle
module reg32_serial_tx #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data_In,
  input  logic             En,
  output logic             Ready,
  output logic             Ser_Out,
  output logic             Frame,
  output logic             Done
);

  // A single-clock bit time still needs a 1-bit divider so the compare is legal.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             tick;

  // tick marks the last clock of the current bit time.
  assign tick = (div == DIV_LAST);

  // State, shift register and counters; reset clears everything at once.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div     <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      div     <= div_nxt;
    end
  end

  // Next-state, shift and counter logic.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_nxt     = div;
    unique case (state)
      S_IDLE: begin
        if (En) begin
          shreg_nxt   = Data_In;
          bit_cnt_nxt = '0;
          div_nxt     = '0;
          state_nxt   = S_START;
        end
      end
      S_START: begin
        div_nxt = tick ? '0 : div + 1'b1;
        if (tick) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        div_nxt = tick ? '0 : div + 1'b1;
        if (tick) begin
          shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        div_nxt = tick ? '0 : div + 1'b1;
        if (tick) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from state and registered datapath only.
  always_comb begin
    Ready   = 1'b0;
    Ser_Out = 1'b1;
    Frame   = 1'b0;
    Done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        Ready = 1'b1;
      end
      S_START: begin
        Ser_Out = 1'b0;
      end
      S_DATA: begin
        Ser_Out = shreg[WIDTH-1];
        Frame   = 1'b1;
      end
      S_STOP: begin
        Done = tick;
      end
      default: begin
        Ser_Out = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/reg32_serial_tx.md
# reg32_serial_tx

Bit-serial transmitter that drains 32-bit words produced by the block's parallel capture registers onto a single output line. Accepts a word via a one-cycle En/Ready load handshake, then sends a framed sequence: start bit, data bits MSB first, stop bit. Each bit is held for a programmable number of clocks. Sits downstream of the enable-gated data registers and is the outbound end of the register-to-link path.

## Interface

- WIDTH, 32: data word width in bits; must be ≥ 2.
- CLKS_PER_BIT, 4: clocks each serial bit is held; must be ≥ 1.

- Clock  input  1  rising-edge system clock.
- Reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- Data_In  input  WIDTH  word to transmit; sampled only on an accepted load.
- En  input  1  load request; accepted on a rising edge where En=1 and Ready=1.
- Ready  output  1  high only in IDLE; block can accept a word.
- Ser_Out  output  1  serial line; idles high.
- Frame  output  1  high during the data-bit phase only.
- Done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation

- States: IDLE, START, DATA, STOP. State, shift register, bit counter and clock-divide counter are all registered.
- All outputs are registered or decoded directly from state, with no combinational path from En or Data_In.
- Reset (async, any state): state=IDLE, Ready=1, Ser_Out=1, Frame=0, Done=0, counters=0, shift register=0. Takes effect immediately, without waiting for a clock edge.
- IDLE: Ser_Out=1. On En=1 the block loads Data_In into the shift register and moves to START. With En=0 it stays in IDLE.
- START: Ser_Out=0 for CLKS_PER_BIT cycles, then moves to DATA.
- DATA: Ser_Out = shift register MSB and Frame=1.
  - Every CLKS_PER_BIT cycles the register shifts left by one and the bit counter increments.
  - After WIDTH bits the block moves to STOP.
- STOP: Ser_Out=1 for CLKS_PER_BIT cycles. Done=1 on the final cycle, then the block returns to IDLE.
- En outside IDLE is ignored. Data_In changes outside the accept edge have no effect.
- The clock-divide counter runs 0..CLKS_PER_BIT-1 and wraps. With CLKS_PER_BIT=1 it is constant 0 and every cycle advances one bit.
- Bit counter width is clog2(WIDTH)+1. There is no wrap inside a frame.

## Timing

- Accept at edge k: Ready=0 from cycle k+1.
- Start bit occupies cycles k+1 .. k+C, where C=CLKS_PER_BIT.
- Data bit j (j=0 is Data_In[WIDTH-1]) occupies cycles k+1+C(1+j) .. k+C(2+j).
- Stop bit occupies the final C cycles. Done is high on the frame's last cycle, k+(WIDTH+2)C.
- Ready=1 on cycle k+(WIDTH+2)C+1. A new word may be accepted at that edge.
- Minimum spacing between accepts is (WIDTH+2)C+1 cycles. The line is high for exactly one cycle between back-to-back frames.
- Done and Ready are never high together.
- Frame rises with the first data bit and falls with the last.
- Reset mid-frame aborts the transmission: the partial word is discarded and Done does not pulse.
- After Reset deasserts, the first edge may accept a word.

## Test plan

- Reset with En=1 and Data_In=32'hDEAD_BEEF held: Ser_Out=1, Ready=1, Frame=0, Done=0 throughout. After release and with En=0, nothing is sent.
- Single word 32'hA5A5_0F0F, C=4, accepted at edge k:
  - Ser_Out=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1,… each held 4 cycles.
  - Stop high for 4 cycles; Done pulses at k+136; Ready=1 at k+137.
- En=1 with Data_In=32'hFFFF_FFFF during data bit 5: serial stream is bit-identical to the undisturbed 32'hA5A5_0F0F frame, and Ready stays 0.
- En held high with 32'h0000_0001 then 32'h8000_0000: the second word is accepted on the first Ready=1 edge. Exactly one idle-high cycle separates the two stop/start bits. The first frame's LSB is 1 and the second frame's MSB is 1.
- Reset pulsed during data bit 10 of 32'h1234_5678: Ser_Out=1 and Frame=0 immediately, with no Done pulse. A following word 32'h0F0F_0F0F then transmits correctly.
- Instance with CLKS_PER_BIT=1, word 32'h1234_5678: frame lasts 34 cycles, bits change every cycle, Done at k+34.
